serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial unsigned adder: the additive counterpart of the ripple full-difference subtractor in the ALU guide.
- Accepts two WIDTH-bit operands on a start request and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Presents a WIDTH+1-bit sum and a per-bit carry vector, then pulses done for one cycle.
- Used by the ALU datapath where area matters more than latency.

Parameters:
- WIDTH, 5, operand width in bits; must be at least 1.
- CW, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  operand A; captured on the accepting edge.
- y  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle, in DONE.
- soma  output  WIDTH+1  result {final carry, sum bits}; held until the next completion.
- carry  output  WIDTH  carry[i] = carry out of bit i; held with soma.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: at a clk edge with reset=1, state=IDLE, busy=0, done=0, soma=0, carry=0, internal shift registers, counter and carry flop cleared. Reset has priority over start.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE -> RUN at an edge with start=1:
  - Load A<=x, B<=y.
  - Clear the carry flop (carry-in 0).
  - count<=0.
  - Clear the working sum/carry shift registers.
- RUN, each edge:
  - s = A[0]^B[0]^c; cn = A[0]&B[0] | c&(A[0]^B[0]).
  - Shift A and B right.
  - Shift s into the MSB of the sum register and cn into the MSB of the carry register (after WIDTH shifts, bit i sits at index i).
  - c<=cn; count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE and load soma<={cn, sum}, carry<={cn, carry_sr[WIDTH-1:1]}, i.e. the final shifted values.
- DONE, one cycle:
  - start=1: accept as in IDLE and go straight to RUN (back-to-back operation, one idle cycle between results).
  - start=0: go to IDLE.
- Latency: accepting edge E0; bits processed at E1..EWIDTH; soma/carry valid and done=1 in the cycle after EWIDTH. Total WIDTH+1 edges from accept to done.
- start during RUN is ignored; no queuing.
- x/y changes after acceptance have no effect.
- soma and carry change only at the DONE transition or on reset; they are stable in IDLE, RUN and DONE.
- Reset mid-RUN aborts the operation:
  - no done pulse;
  - soma/carry cleared to 0 (not the previous result).
- Width: unsigned addition, no overflow loss; soma[WIDTH] = final carry = carry[WIDTH-1].
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=5; x=01011, y=00111, start pulse -> busy high 5 cycles, done for 1 cycle at edge 6, soma=010010 (18), carry=01111.
- x=11001, y=01101 -> soma=100110 (38), carry=11001.
- x=11111, y=11111 -> soma=111110 (62), carry=11111; then x=00000, y=00000 -> soma=000000, carry=00000.
- Start held high continuously with x=00001, y=00001 -> results every 6 edges, soma=000010, carry=00001. Pulses of start and changes of x/y during RUN leave soma unaffected.
- Reset asserted at the 3rd RUN edge of 11001+01101 -> no done, busy=0, soma=0, carry=0 the next cycle. A subsequent start of 01011+00111 yields 010010.
- Reset and start high on the same edge -> remains IDLE, busy=0.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. Two WIDTH-bit operands are captured on a start
// request and summed one bit per clock, LSB first, through a single full-adder
// cell and a carry flop. The completed sum and the per-bit carry vector are
// presented together with a one-cycle done pulse and held until the next
// completion.
//
// Ports:
//   clk    in   1        rising-edge clock
//   reset  in   1        synchronous active-high reset (priority over start)
//   start  in   1        request, sampled only in IDLE or DONE
//   x      in   WIDTH    operand A, captured on the accepting edge
//   y      in   WIDTH    operand B, captured on the accepting edge
//   busy   out  1        high while bits are being processed (RUN)
//   done   out  1        high for exactly one cycle when the result is loaded
//   soma   out  WIDTH+1  {final carry, sum bits}
//   carry  out  WIDTH    carry[i] = carry out of bit i
//
// Timing: accepting edge E0, bits processed at E1..E(WIDTH), done=1 in the
// cycle following E(WIDTH). With start held high in DONE the next operation
// is accepted immediately, giving one result every WIDTH+1 edges.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 5,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   soma,
    output logic [WIDTH-1:0] carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    // Working registers of the serial datapath.
    logic [WIDTH-1:0] a_sr;      // operand A, shifted right each RUN cycle
    logic [WIDTH-1:0] b_sr;      // operand B, shifted right each RUN cycle
    logic [WIDTH-1:0] sum_sr;    // sum bits enter at the MSB
    logic [WIDTH-1:0] carry_sr;  // carry-out bits enter at the MSB
    logic             c;         // carry flop between successive bits
    logic [CW-1:0]    count;     // index of the bit processed at the next edge

    // Combinational helpers.
    logic             accept;    // operands are captured at this edge
    logic             finish;    // last bit is processed at this edge
    logic             s_bit;
    logic             cn_bit;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] carry_shift;

    // -------------------------------------------------------------------------
    // Full-adder cell and the shifted views of the result registers.
    // Shifting right then overwriting the MSB keeps this valid for WIDTH=1,
    // where a {bit, vec[WIDTH-1:1]} concatenation would be an illegal range.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so
        // no path through the block leaves it unassigned (which infers a latch).
        s_bit       = a_sr[0] ^ b_sr[0] ^ c;
        cn_bit      = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));

        sum_shift   = sum_sr >> 1;
        sum_shift[WIDTH-1] = s_bit;

        carry_shift = carry_sr >> 1;
        carry_shift[WIDTH-1] = cn_bit;
    end

    // -------------------------------------------------------------------------
    // FSM: state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic and datapath strobes.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                // start is deliberately ignored here; nothing is queued.
                if (count == LAST_BIT) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift registers are ordinary flops, not a memory, so
            // they are cleared here; a reset mid-operation must leave no trace
            // of the aborted result.
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry_sr <= '0;
            c        <= 1'b0;
            count    <= '0;
            soma     <= '0;
            carry    <= '0;
        end else begin
            if (accept) begin
                a_sr     <= x;
                b_sr     <= y;
                sum_sr   <= '0;
                carry_sr <= '0;
                c        <= 1'b0;
                count    <= '0;
            end else if (state == ST_RUN) begin
                a_sr     <= a_sr >> 1;
                b_sr     <= b_sr >> 1;
                sum_sr   <= sum_shift;
                carry_sr <= carry_shift;
                c        <= cn_bit;
                count    <= count + CW'(1);
            end

            // The published result changes only here, so it stays stable
            // through IDLE, RUN and DONE.
            if (finish) begin
                soma  <= {cn_bit, sum_shift};
                carry <= carry_shift;
            end
        end
    end

    // Status outputs decode the state register only; no input reaches them
    // without passing through a flop.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=5). Expected sums and carry
// vectors come from a reference model using plain integer arithmetic:
// soma = x + y, and carry[i] is the overflow of adding the low i+1 bits.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W:0]   soma;
    logic [W-1:0] carry;

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .soma  (soma),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [W:0] model_soma(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'(a) + int'(b);
        return s[W:0];
    endfunction

    function automatic logic [W-1:0] model_carry(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int mask;
        int part;
        r = '0;
        for (int i = 0; i < W; i++) begin
            mask = (1 << (i + 1)) - 1;
            part = (int'(a) & mask) + (int'(b) & mask);
            r[i] = ((part >> (i + 1)) & 1) != 0;
        end
        return r;
    endfunction

    // Advance one clock and settle 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one complete operation: accept, wait (bounded) for done, then
    // one more edge. Reports what was seen; callers compare.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] got_soma, output logic [W-1:0] got_carry,
                         output int busy_cycles, output logic done_at_end,
                         output logic done_after);
        start = 1'b1;
        x     = a;
        y     = b;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            tick();
        end
        done_at_end = done;
        got_soma    = soma;
        got_carry   = carry;
        tick();
        done_after  = done;
    endtask

    // Compare one finished operation against the model.
    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W:0] got_soma, input logic [W-1:0] got_carry,
                            input int busy_cycles, input logic done_at_end,
                            input logic done_after);
        logic [W:0]   es;
        logic [W-1:0] ec;
        es = model_soma(a, b);
        ec = model_carry(a, b);
        n_checks += 5;
        if (got_soma !== es) begin
            n_fail++;
            $display("FAIL %s soma: got %b expected %b", name, got_soma, es);
        end
        if (got_carry !== ec) begin
            n_fail++;
            $display("FAIL %s carry: got %b expected %b", name, got_carry, ec);
        end
        if (busy_cycles != W) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, W);
        end
        if (done_at_end !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b expected 1", name, done_at_end);
        end
        if (done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_one_cycle: got %b expected 0", name, done_after);
        end
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        tick();
        tick();
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        if (soma !== '0)   begin n_fail++; $display("FAIL reset soma: got %b expected 0", soma); end
        if (carry !== '0)  begin n_fail++; $display("FAIL reset carry: got %b expected 0", carry); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W:0]   gs;
        logic [W-1:0] gc;
        int           bc;
        logic         d0, d1;
        va = '{5'b01011, 5'b11001, 5'b11111, 5'b00000, 5'b10000};
        vb = '{5'b00111, 5'b01101, 5'b11111, 5'b00000, 5'b10000};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], gs, gc, bc, d0, d1);
            check_op($sformatf("vector%0d", i), va[i], vb[i], gs, gc, bc, d0, d1);
        end
        // Spot-check the documented values directly as well.
        do_op(5'b01011, 5'b00111, gs, gc, bc, d0, d1);
        n_checks += 2;
        if (gs !== 6'b010010) begin n_fail++; $display("FAIL doc18 soma: got %b expected 010010", gs); end
        if (gc !== 5'b01111)  begin n_fail++; $display("FAIL doc18 carry: got %b expected 01111", gc); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [W:0]   gs;
        logic [W-1:0] gc;
        int           bc;
        logic         d0, d1;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            do_op(a, b, gs, gc, bc, d0, d1);
            check_op($sformatf("random%0d", i), a, b, gs, gc, bc, d0, d1);
        end
    endtask

    // start held high: a new result every W+1 edges with no idle gap.
    task automatic test_back_to_back();
        logic [W:0]   es;
        logic [W-1:0] ec;
        es = model_soma(5'b00001, 5'b00001);
        ec = model_carry(5'b00001, 5'b00001);
        start = 1'b1;
        x     = 5'b00001;
        y     = 5'b00001;
        tick();                       // accepting edge
        for (int r = 0; r < 3; r++) begin
            repeat (W) tick();
            n_checks += 3;
            if (done !== 1'b1) begin n_fail++; $display("FAIL b2b%0d done: got %b expected 1", r, done); end
            if (soma !== es)   begin n_fail++; $display("FAIL b2b%0d soma: got %b expected %b", r, soma, es); end
            if (carry !== ec)  begin n_fail++; $display("FAIL b2b%0d carry: got %b expected %b", r, carry, ec); end
            tick();                   // DONE with start=1 re-accepts
            n_checks += 2;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b%0d restart busy: got %b expected 1", r, busy); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL b2b%0d restart done: got %b expected 0", r, done); end
        end
        start = 1'b0;
        repeat (W + 2) tick();
    endtask

    // start pulses and operand changes during RUN must not disturb anything.
    task automatic test_ignore_during_run();
        logic [W:0]   prev;
        logic [W:0]   es;
        logic [W-1:0] ec;
        prev = soma;
        es   = model_soma(5'b11001, 5'b01101);
        ec   = model_carry(5'b11001, 5'b01101);
        start = 1'b1;
        x     = 5'b11001;
        y     = 5'b01101;
        tick();
        start = 1'b0;
        for (int i = 1; i < W; i++) begin
            start = i[0];
            x     = W'($urandom);
            y     = W'($urandom);
            n_checks += 2;
            if (soma !== prev) begin n_fail++; $display("FAIL run_hold%0d soma: got %b expected %b", i, soma, prev); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL run_hold%0d busy: got %b expected 1", i, busy); end
            tick();
        end
        start = 1'b0;
        tick();                       // edge E(W)
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL run_ignore done: got %b expected 1", done); end
        if (soma !== es)   begin n_fail++; $display("FAIL run_ignore soma: got %b expected %b", soma, es); end
        if (carry !== ec)  begin n_fail++; $display("FAIL run_ignore carry: got %b expected %b", carry, ec); end
        tick();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL run_ignore idle busy: got %b expected 0", busy); end
        if (soma !== es)   begin n_fail++; $display("FAIL run_ignore hold soma: got %b expected %b", soma, es); end
    endtask

    task automatic test_reset_mid_run();
        logic         seen_done;
        logic [W:0]   gs;
        logic [W-1:0] gc;
        int           bc;
        logic         d0, d1;
        start = 1'b1;
        x     = 5'b11001;
        y     = 5'b01101;
        tick();                       // E0
        start = 1'b0;
        tick();                       // E1
        tick();                       // E2
        reset = 1'b1;
        tick();                       // E3 with reset
        reset = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b expected 0", done); end
        if (soma !== '0)   begin n_fail++; $display("FAIL abort soma: got %b expected 0", soma); end
        if (carry !== '0)  begin n_fail++; $display("FAIL abort carry: got %b expected 0", carry); end
        seen_done = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_checks++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort no_done: got %b expected 0", seen_done); end
        do_op(5'b01011, 5'b00111, gs, gc, bc, d0, d1);
        check_op("after_abort", 5'b01011, 5'b00111, gs, gc, bc, d0, d1);
    endtask

    task automatic test_reset_start_same_edge();
        reset = 1'b1;
        start = 1'b1;
        x     = 5'b11111;
        y     = 5'b00001;
        tick();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start busy: got %b expected 0", busy); end
        if (soma !== '0)   begin n_fail++; $display("FAIL reset_start soma: got %b expected 0", soma); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start later busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_start later done: got %b expected 0", done); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        x        = '0;
        y        = '0;

        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_ignore_during_run();
        test_reset_mid_run();
        test_reset_start_same_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
